// File: rtl/tcam_match_encoder.sv
// Serialises one captured TCAM match vector into matched entry addresses, lowest index first.
// Latency: 1 cycle from capture to the first hit. Backpressure: hit_addr/hit_last hold while out_ready=0.
// Optional TCAM_ENC_FIRST_ONLY_EN: emit only the highest-priority hit (hit_count still full popcount).
module tcam_match_encoder #(
    parameter int ENTRIES = 20,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ENTRIES-1:0] match_vec,
    input  logic               match_valid,
    output logic               load_ready,
    output logic               hit_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  hit_addr,
    output logic               hit_last,
    output logic [CNT_W-1:0]   hit_count,
    output logic               miss
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [ENTRIES-1:0] ONE = ENTRIES'(1);

    state_t             state;
    logic [ENTRIES-1:0] pending;
    logic [CNT_W-1:0]   popcnt;
    logic [ADDR_W-1:0]  low_idx;
    logic               single;
    logic               xfer;

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            popcnt = popcnt + CNT_W'(match_vec[i]);
        end
    end

    // Scanning downward lets the lowest set bit win the final assignment.
    always_comb begin
        low_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = ADDR_W'(i);
            end
        end
    end

    assign single     = (pending != '0) && ((pending & (pending - ONE)) == '0);
    assign load_ready = (state == IDLE);
    assign hit_valid  = (state == EMIT);
    assign hit_addr   = low_idx;
    assign xfer       = hit_valid & out_ready;

`ifdef TCAM_ENC_FIRST_ONLY_EN
    assign hit_last = hit_valid;
`else
    assign hit_last = hit_valid & single;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= '0;
            hit_count <= '0;
            miss      <= 1'b0;
        end else begin
            miss <= 1'b0;
            case (state)
                IDLE: begin
                    if (match_valid) begin
                        hit_count <= popcnt;
                        if (match_vec != '0) begin
                            pending <= match_vec;
                            state   <= EMIT;
                        end else begin
                            miss <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // Clearing pending on exit keeps hit_addr at 0 while idle in both builds.
                    if (xfer) begin
                        if (hit_last) begin
                            pending <= '0;
                            state   <= IDLE;
                        end else begin
                            pending <= pending & (pending - ONE);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
